fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bundle: ROM port, redirect from execute, fetch->decode handshake.
// The master modport is the fetch unit; the slave modport is the surrounding core/ROM.
interface fetch_if #(
    parameter int ADDR_W = 4,
    parameter int INST_W = 16
);
    logic              run;
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_inst;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              if_valid;
    logic              if_ready;
    logic [INST_W-1:0] if_inst;
    logic [ADDR_W-1:0] if_pc;
    logic [7:0]        fetch_count;

    modport master (
        input  run, rom_inst, redirect_valid, redirect_target, if_ready,
        output rom_addr, if_valid, if_inst, if_pc, fetch_count
    );

    modport slave (
        output run, rom_inst, redirect_valid, redirect_target, if_ready,
        input  rom_addr, if_valid, if_inst, if_pc, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register drives a combinational ROM, one-entry output register feeds decode.
// Latency: instruction appears on if_valid one edge after fetch; one per cycle when if_ready stays high.
// Backpressure: if_ready=0 with a held instruction freezes the output register and the PC.
module fetch_unit #(
    parameter int                ADDR_W   = 4,
    parameter int                INST_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [INST_W-1:0] if_inst_q, if_inst_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [7:0]        fetch_count_q, fetch_count_d;
    logic              load;
    logic              accept;

    assign accept = if_valid_q && bus.if_ready;
    // Refill the output register whenever it is empty or being drained this edge.
    assign load   = (state_q == RUN) && bus.run && !bus.redirect_valid
                    && (!if_valid_q || bus.if_ready);

    always_comb begin
        state_d       = bus.run ? RUN : IDLE;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_inst_d     = if_inst_q;
        if_pc_d       = if_pc_q;
        fetch_count_d = fetch_count_q;

        if (bus.redirect_valid) begin
            pc_d       = bus.redirect_target;
            if_valid_d = 1'b0;
        end else if (load) begin
            if_inst_d  = bus.rom_inst;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + ADDR_W'(1);
        end else if (accept) begin
            if_valid_d = 1'b0;
        end

        // A transfer completes even on a redirect edge, so it still counts.
        if (accept && (fetch_count_q != 8'hFF)) begin
            fetch_count_d = fetch_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_inst_q     <= '0;
            if_pc_q       <= '0;
            fetch_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_inst_q     <= if_inst_d;
            if_pc_q       <= if_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.rom_addr    = pc_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.if_inst     = if_inst_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with ROM model rom_inst = 16'h1000 + rom_addr.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    fetch_if #(.ADDR_W(4), .INST_W(16)) bus ();

    assign bus.rom_inst = 16'h1000 + {12'h000, bus.rom_addr};

    fetch_unit #(.ADDR_W(4), .INST_W(16), .RESET_PC(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n               = 1'b0;
        bus.run             = 1'b0;
        bus.if_ready        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Starts streaming with if_ready=1; returns at the falling edge where if_pc=k is shown.
    task automatic stream_to(input int k);
        bus.run      = 1'b1;
        bus.if_ready = 1'b1;
        repeat (k + 2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.run = 1'b0; bus.if_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 4'd0;
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.if_valid); end
        n_checks++;
        if (bus.if_inst !== 16'h0000) begin n_fail++; $display("FAIL reset_inst: got %h want 0000", bus.if_inst); end
        n_checks++;
        if (bus.if_pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", bus.if_pc); end
        n_checks++;
        if (bus.rom_addr !== 4'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d want 0", bus.rom_addr); end
        n_checks++;
        if (bus.fetch_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.fetch_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_stream_wrap();
        logic [15:0] exp_inst;
        do_reset();
        bus.run = 1'b1; bus.if_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_edge_valid: got %b want 0", bus.if_valid); end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_inst = 16'h1000 + 16'(i);
            n_checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 4'(i) || bus.if_inst !== exp_inst) begin
                n_fail++;
                $display("FAIL stream_%0d: got v=%b pc=%0d inst=%h want v=1 pc=%0d inst=%h",
                         i, bus.if_valid, bus.if_pc, bus.if_inst, i, exp_inst);
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.if_pc !== 4'd0 || bus.if_inst !== 16'h1000) begin
            n_fail++; $display("FAIL wrap: got pc=%0d inst=%h want pc=0 inst=1000", bus.if_pc, bus.if_inst);
        end
        n_checks++;
        if (bus.fetch_count !== 8'd16) begin n_fail++; $display("FAIL wrap_count: got %0d want 16", bus.fetch_count); end
    endtask

    task automatic test_stall();
        do_reset();
        stream_to(4);
        bus.if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 4'd4 || bus.if_inst !== 16'h1004 || bus.rom_addr !== 4'd5) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got v=%b pc=%0d inst=%h rom=%0d want v=1 pc=4 inst=1004 rom=5",
                         i, bus.if_valid, bus.if_pc, bus.if_inst, bus.rom_addr);
            end
        end
        bus.if_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 4'd5 || bus.if_inst !== 16'h1005) begin
            n_fail++; $display("FAIL stall_release: got v=%b pc=%0d inst=%h want v=1 pc=5 inst=1005",
                               bus.if_valid, bus.if_pc, bus.if_inst);
        end
        n_checks++;
        if (bus.fetch_count !== 8'd5) begin n_fail++; $display("FAIL stall_count: got %0d want 5", bus.fetch_count); end
    endtask

    task automatic test_redirect();
        do_reset();
        stream_to(6);
        bus.if_ready = 1'b0;
        @(negedge clk);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 4'd10;
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b0 || bus.rom_addr !== 4'd10) begin
            n_fail++; $display("FAIL redirect_flush: got v=%b rom=%0d want v=0 rom=10", bus.if_valid, bus.rom_addr);
        end
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 4'd10 || bus.if_inst !== 16'h100A) begin
            n_fail++; $display("FAIL redirect_target: got v=%b pc=%0d inst=%h want v=1 pc=10 inst=100a",
                               bus.if_valid, bus.if_pc, bus.if_inst);
        end
        bus.if_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.if_pc !== 4'd11 || bus.fetch_count !== 8'd7) begin
            n_fail++; $display("FAIL redirect_after: got pc=%0d count=%0d want pc=11 count=7", bus.if_pc, bus.fetch_count);
        end
    endtask

    task automatic test_run_stop_and_idle_redirect();
        do_reset();
        stream_to(3);
        bus.run = 1'b0;
        bus.if_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 4'd3 || bus.rom_addr !== 4'd4 || bus.fetch_count !== 8'd3) begin
            n_fail++; $display("FAIL idle_hold: got v=%b pc=%0d rom=%0d count=%0d want v=1 pc=3 rom=4 count=3",
                               bus.if_valid, bus.if_pc, bus.rom_addr, bus.fetch_count);
        end
        bus.if_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b0 || bus.rom_addr !== 4'd4 || bus.fetch_count !== 8'd4) begin
            n_fail++; $display("FAIL idle_drain: got v=%b rom=%0d count=%0d want v=0 rom=4 count=4",
                               bus.if_valid, bus.rom_addr, bus.fetch_count);
        end
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 4'd12;
        @(negedge clk);
        n_checks++;
        if (bus.rom_addr !== 4'd12 || bus.if_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_redirect: got rom=%0d v=%b want rom=12 v=0", bus.rom_addr, bus.if_valid);
        end
        bus.redirect_valid = 1'b0;
        bus.run = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL resume_first_edge: got v=%b want 0", bus.if_valid); end
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 4'd12 || bus.if_inst !== 16'h100C) begin
            n_fail++; $display("FAIL resume_target: got v=%b pc=%0d inst=%h want v=1 pc=12 inst=100c",
                               bus.if_valid, bus.if_pc, bus.if_inst);
        end
    endtask

    task automatic test_async_reset_and_saturate();
        do_reset();
        stream_to(9);
        bus.if_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.if_valid !== 1'b0 || bus.if_pc !== 4'd0 || bus.if_inst !== 16'h0000
            || bus.rom_addr !== 4'd0 || bus.fetch_count !== 8'd0) begin
            n_fail++; $display("FAIL async_reset: got v=%b pc=%0d inst=%h rom=%0d count=%0d want all zero",
                               bus.if_valid, bus.if_pc, bus.if_inst, bus.rom_addr, bus.fetch_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stream_to(0);
        n_checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 4'd0 || bus.if_inst !== 16'h1000) begin
            n_fail++; $display("FAIL post_reset_first: got v=%b pc=%0d inst=%h want v=1 pc=0 inst=1000",
                               bus.if_valid, bus.if_pc, bus.if_inst);
        end
        repeat (254) @(negedge clk);
        n_checks++;
        if (bus.fetch_count !== 8'd254) begin n_fail++; $display("FAIL count_254: got %0d want 254", bus.fetch_count); end
        @(negedge clk);
        n_checks++;
        if (bus.fetch_count !== 8'd255) begin n_fail++; $display("FAIL count_255: got %0d want 255", bus.fetch_count); end
        repeat (46) @(negedge clk);
        n_checks++;
        if (bus.fetch_count !== 8'd255) begin n_fail++; $display("FAIL count_saturate: got %0d want 255", bus.fetch_count); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.run = 1'b0; bus.if_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 4'd0;
        @(negedge clk);
        test_reset();
        test_stream_wrap();
        test_stall();
        test_redirect();
        test_run_stop_and_idle_redirect();
        test_async_reset_and_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
